// File: rtl/control_unit_decode_pipe.sv
// Registered opcode decoder feeding a 2-entry skid FIFO with valid/ready flow control and flush.
// Optional per-class pop counters are compiled in with DECODE_PERF_CNT_EN.
module control_unit_decode_pipe #(
   parameter int OPCODE_W = 5,
   parameter int TAG_W    = 32,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [TAG_W-1:0]    out_tag,
   output logic [18:0]         ctrl,
   output logic                illegal
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    cnt_int,
   output logic [CNT_W-1:0]    cnt_fp,
   output logic [CNT_W-1:0]    cnt_vec,
   output logic [CNT_W-1:0]    cnt_ctrl,
   output logic [CNT_W-1:0]    cnt_ill
`endif
);

   localparam int B_ALUOP = 15, B_REGDST = 14, B_ALUSRC = 13, B_MEMRD = 12, B_MEMWR = 11;
   localparam int B_MEM2R = 10, B_REGWR = 9, B_BR = 8, B_BROP = 7, B_RS1 = 6, B_RS2 = 5;
   localparam int B_ALUDST = 4, B_VEC = 3, B_PF = 2, B_IMM = 1, B_INT = 0;

   // Entry layout: {cls[1:0], illegal, ctrl[18:0], tag}
   localparam int EW = TAG_W + 22;

   logic [18:0]    dec_ctrl;
   logic           dec_ill;
   logic [1:0]     cls;
   logic [EW-1:0]  new_ent;
   logic [EW-1:0]  ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]     cnt_q, cnt_d;
   logic           push, pop;

   assign cls = opcode[4:3];

   always_comb begin
      dec_ctrl = '0;
      dec_ill  = 1'b0;
      if (cls != 2'b11) begin
         dec_ctrl[B_INT] = (cls == 2'b00);
         dec_ctrl[B_PF]  = (cls == 2'b01);
         dec_ctrl[B_VEC] = (cls == 2'b10);
         dec_ctrl[B_RS1] = (cls == 2'b01) || (cls == 2'b10);
         if (!opcode[2]) begin
            dec_ctrl[B_ALUOP +: 4] = {opcode[4:3], opcode[1:0]};
            dec_ctrl[B_REGDST]     = 1'b1;
            dec_ctrl[B_REGWR]      = 1'b1;
            dec_ctrl[B_ALUDST]     = 1'b1;
         end else if (!opcode[1]) begin
            dec_ctrl[B_ALUSRC] = 1'b1;
            dec_ctrl[B_IMM]    = 1'b1;
            if (!opcode[0]) begin
               dec_ctrl[B_MEMRD] = 1'b1;
               dec_ctrl[B_MEM2R] = 1'b1;
               dec_ctrl[B_REGWR] = 1'b1;
            end else begin
               dec_ctrl[B_MEMWR] = 1'b1;
               dec_ctrl[B_RS2]   = 1'b1;
            end
         end else begin
            dec_ill = 1'b1;
         end
      end else begin
         case (opcode[2:0])
            3'b000: ;
            3'b100: begin
               dec_ctrl[B_BR]         = 1'b1;
               dec_ctrl[B_ALUOP +: 4] = 4'b0001;
            end
            3'b101: begin
               dec_ctrl[B_BR]   = 1'b1;
               dec_ctrl[B_BROP] = 1'b1;
            end
            default: dec_ill = 1'b1;
         endcase
      end
      // Any set bit above the 5-bit base opcode makes the op undefined.
      if ((opcode >> 5) != '0) dec_ill = 1'b1;
      if (dec_ill) dec_ctrl = '0;
   end

   assign new_ent   = {cls, dec_ill, dec_ctrl, in_tag};
   assign in_ready  = (cnt_q != 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt_q == 2'd0) ent0_d = new_ent;
               else               ent1_d = new_ent;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               ent0_d = ent1_q;
               cnt_d  = cnt_q - 2'd1;
            end
            // push needs count<2 and pop needs count>0, so count is 1 here
            2'b11: ent0_d = new_ent;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_tag = ent0_q[TAG_W-1:0];
   assign ctrl    = ent0_q[TAG_W +: 19];
   assign illegal = ent0_q[EW-3];

`ifdef DECODE_PERF_CNT_EN
   // Counter slots: 0 INT, 1 FP, 2 VEC, 3 CTRL, 4 illegal
   logic [4:0][CNT_W-1:0] pc_q, pc_d;
   logic [2:0]            pc_sel;

   always_comb begin
      pc_d   = pc_q;
      pc_sel = ent0_q[EW-3] ? 3'd4 : {1'b0, ent0_q[EW-1:EW-2]};
      if (pop && (pc_q[pc_sel] != '1)) pc_d[pc_sel] = pc_q[pc_sel] + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_q <= '0;
      else      pc_q <= pc_d;
   end

   assign cnt_int  = pc_q[0];
   assign cnt_fp   = pc_q[1];
   assign cnt_vec  = pc_q[2];
   assign cnt_ctrl = pc_q[3];
   assign cnt_ill  = pc_q[4];
`endif

endmodule

// File: tb/tb_control_unit_decode_pipe.sv
// Randomized and directed bench for control_unit_decode_pipe against a queue-based reference model.
module tb_control_unit_decode_pipe;
   localparam int OW = 5, TW = 32, CW = 2;

   logic          clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [OW-1:0] opcode = '0;
   logic [TW-1:0] in_tag = '0;
   logic          in_ready, out_valid, illegal;
   logic [TW-1:0] out_tag;
   logic [18:0]   ctrl;

   logic          in_valid8 = 1'b0, out_ready8 = 1'b1;
   logic [7:0]    opcode8 = '0;
   logic [TW-1:0] in_tag8 = '0;
   logic          in_ready8, out_valid8, illegal8;
   logic [TW-1:0] out_tag8;
   logic [18:0]   ctrl8;

`ifdef DECODE_PERF_CNT_EN
   logic [CW-1:0] cnt_int, cnt_fp, cnt_vec, cnt_ctrl, cnt_ill;
   logic [CW-1:0] c8_int, c8_fp, c8_vec, c8_ctrl, c8_ill;
`endif

   control_unit_decode_pipe #(.OPCODE_W(OW), .TAG_W(TW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_tag(out_tag), .ctrl(ctrl), .illegal(illegal)
`ifdef DECODE_PERF_CNT_EN
      , .cnt_int(cnt_int), .cnt_fp(cnt_fp), .cnt_vec(cnt_vec), .cnt_ctrl(cnt_ctrl), .cnt_ill(cnt_ill)
`endif
   );

   control_unit_decode_pipe #(.OPCODE_W(8), .TAG_W(TW), .CNT_W(CW)) dut8 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
      .opcode(opcode8), .in_tag(in_tag8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out_tag(out_tag8), .ctrl(ctrl8), .illegal(illegal8)
`ifdef DECODE_PERF_CNT_EN
      , .cnt_int(c8_int), .cnt_fp(c8_fp), .cnt_vec(c8_vec), .cnt_ctrl(c8_ctrl), .cnt_ill(c8_ill)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [18:0]   c;
      bit            ill;
      logic [TW-1:0] tag;
   } ent_t;

   ent_t q[$];
   int   checks = 0, errors = 0;

   // Reference decode: opcode split arithmetically into class (op/8) and sub-op (op%8).
   function automatic void ref_dec(input int op, input bit hi, output logic [18:0] c, output bit ill);
      int cls, sub;
      logic [3:0] aluop;
      bit regdst, alusrc, mr, mw, m2r, rw, br, bop, rs1, rs2, ad, vo, pf, imm, io;
      cls = op / 8; sub = op % 8; aluop = 4'd0;
      {regdst, alusrc, mr, mw, m2r, rw, br, bop, rs1, rs2, ad, vo, pf, imm, io} = '0;
      ill = 1'b0;
      if (cls < 3) begin
         io = (cls == 0); pf = (cls == 1); vo = (cls == 2); rs1 = (cls == 1 || cls == 2);
         if (sub < 4) begin aluop = 4'(cls * 4 + sub); regdst = 1; rw = 1; ad = 1; end
         else if (sub == 4) begin alusrc = 1; imm = 1; mr = 1; m2r = 1; rw = 1; end
         else if (sub == 5) begin alusrc = 1; imm = 1; mw = 1; rs2 = 1; end
         else ill = 1;
      end else if (sub == 4) begin br = 1; aluop = 4'd1; end
      else if (sub == 5) begin br = 1; bop = 1; end
      else if (sub != 0) ill = 1;
      if (hi) ill = 1;
      c = ill ? 19'd0 : {aluop, regdst, alusrc, mr, mw, m2r, rw, br, bop, rs1, rs2, ad, vo, pf, imm, io};
   endfunction

   // Advance one clock, updating the model from the inputs present before the edge.
   task automatic step();
      bit acc, pp;
      ent_t e;
      acc = in_valid && (q.size() < 2) && !flush;
      pp  = (q.size() > 0) && out_ready;
      ref_dec(int'(opcode), 1'b0, e.c, e.ill);
      e.tag = in_tag;
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (pp) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
      checks++; if (ctrl !== 19'd0 || illegal !== 1'b0 || out_tag !== '0)
         begin errors++; $display("FAIL reset outputs got ctrl=%h ill=%b tag=%h want 0", ctrl, illegal, out_tag); end
      @(posedge clk); #1 rst = 1'b1;
      // reset asserted with two ops buffered
      out_ready = 1'b0; in_valid = 1'b1;
      opcode = 5'b00001; in_tag = $urandom; step();
      opcode = 5'b01000; in_tag = $urandom; step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
         begin errors++; $display("FAIL pre_reset_full got v=%b r=%b want 1 0", out_valid, in_ready); end
      #2 rst = 1'b0; q.delete();
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ctrl !== 19'd0)
         begin errors++; $display("FAIL midstream_reset got v=%b r=%b ctrl=%h want 0 1 0", out_valid, in_ready, ctrl); end
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      int ops[8]     = '{0, 1, 4, 8, 12, 16, 20, 29};
      int exp_alu[8] = '{0, 1, 0, 4, 0, 8, 0, 0};
      logic [TW-1:0] t;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         opcode = 5'(ops[i]); t = $urandom; in_tag = t; in_valid = 1'b1;
         step();
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_tag !== t || ctrl !== q[0].c || illegal !== 1'b0)
            begin errors++; $display("FAIL b2b op%0d got v=%b r=%b tag=%h ctrl=%h want 1 1 %h %h", i, out_valid, in_ready, out_tag, ctrl, t, q[0].c); end
         checks++; if (ctrl[18:15] !== 4'(exp_alu[i]))
            begin errors++; $display("FAIL b2b_aluop op%0d got %h want %h", i, ctrl[18:15], exp_alu[i]); end
      end
      checks++; if (ctrl[8] !== 1'b1 || ctrl[7] !== 1'b1)
         begin errors++; $display("FAIL b2b_branch got Branch=%b BranchOp=%b want 1 1", ctrl[8], ctrl[7]); end
      in_valid = 1'b0; step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [TW-1:0] ta, tb, tc;
      logic [18:0] ca;
      out_ready = 1'b0; in_valid = 1'b1;
      ta = $urandom; tb = $urandom; tc = $urandom;
      opcode = 5'b00100; in_tag = ta; step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first in_ready got %b want 1", in_ready); end
      ca = q[0].c;
      opcode = 5'b10001; in_tag = tb; step();
      opcode = 5'b01101; in_tag = tc;
      for (int i = 0; i < 3; i++) begin
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== ta || ctrl !== ca)
            begin errors++; $display("FAIL bp_hold c%0d got r=%b v=%b tag=%h ctrl=%h want 0 1 %h %h", i, in_ready, out_valid, out_tag, ctrl, ta, ca); end
         step();
      end
      out_ready = 1'b1; step();
      checks++; if (out_tag !== tb || ctrl !== q[0].c) begin errors++; $display("FAIL bp_drain1 got tag=%h want %h", out_tag, tb); end
      step();
      in_valid = 1'b0;
      checks++; if (out_tag !== tc || ctrl !== q[0].c) begin errors++; $display("FAIL bp_drain2 got tag=%h want %h", out_tag, tc); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
   endtask

   task automatic test_illegal();
      int ops[2] = '{31, 6};
      logic [18:0] c; bit il;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         opcode = 5'(ops[i]); in_tag = $urandom; in_valid = 1'b1; step();
         checks++; if (illegal !== 1'b1 || ctrl !== 19'd0 || out_valid !== 1'b1)
            begin errors++; $display("FAIL illegal op=%0d got ill=%b ctrl=%h v=%b want 1 0 1", ops[i], illegal, ctrl, out_valid); end
      end
      in_valid = 1'b0; step();
      opcode8 = 8'h20; in_tag8 = $urandom; in_valid8 = 1'b1; step();
      checks++; if (illegal8 !== 1'b1 || ctrl8 !== 19'd0 || out_valid8 !== 1'b1)
         begin errors++; $display("FAIL illegal_w8 got ill=%b ctrl=%h v=%b want 1 0 1", illegal8, ctrl8, out_valid8); end
      opcode8 = 8'h01; step();
      ref_dec(1, 1'b0, c, il);
      checks++; if (illegal8 !== 1'b0 || ctrl8 !== c)
         begin errors++; $display("FAIL legal_w8 got ill=%b ctrl=%h want 0 %h", illegal8, ctrl8, c); end
      in_valid8 = 1'b0; step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      opcode = 5'b00000; in_tag = $urandom; step();
      opcode = 5'b11100; in_tag = $urandom; step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre in_ready got %b want 0", in_ready); end
      flush = 1'b1; opcode = 5'b00001; step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         begin errors++; $display("FAIL flush got v=%b r=%b want 0 1", out_valid, in_ready); end
      flush = 1'b0; in_valid = 1'b0; step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got v=%b want 0", out_valid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 25) == 0;
         opcode    = 5'($urandom);
         in_tag    = $urandom;
         step();
         checks++; if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0))
            begin errors++; $display("FAIL rand_flow c%0d got r=%b v=%b want depth %0d", i, in_ready, out_valid, q.size()); end
         if (q.size() > 0) begin
            checks++; if (ctrl !== q[0].c || illegal !== q[0].ill || out_tag !== q[0].tag)
               begin errors++; $display("FAIL rand_head c%0d got %h/%b/%h want %h/%b/%h", i, ctrl, illegal, out_tag, q[0].c, q[0].ill, q[0].tag); end
         end
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step(); step();
   endtask

`ifdef DECODE_PERF_CNT_EN
   task automatic test_perf();
      #2 rst = 1'b0; q.delete();
      @(posedge clk); #1 rst = 1'b1;
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin opcode = 5'($urandom_range(0, 5)); step(); end
      in_valid = 1'b0; step(); step();
      checks++; if (cnt_int !== 2'd3 || cnt_fp !== 2'd0 || cnt_vec !== 2'd0 || cnt_ctrl !== 2'd0 || cnt_ill !== 2'd0)
         begin errors++; $display("FAIL perf_int got %0d %0d %0d %0d %0d want 3 0 0 0 0", cnt_int, cnt_fp, cnt_vec, cnt_ctrl, cnt_ill); end
      in_valid = 1'b1; opcode = 5'd6; step(); opcode = 5'd8; step(); opcode = 5'd24; step();
      in_valid = 1'b0; step(); step();
      checks++; if (cnt_ill !== 2'd1 || cnt_fp !== 2'd1 || cnt_ctrl !== 2'd1 || cnt_int !== 2'd3)
         begin errors++; $display("FAIL perf_mix got ill=%0d fp=%0d ctrl=%0d int=%0d want 1 1 1 3", cnt_ill, cnt_fp, cnt_ctrl, cnt_int); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_flush();
      test_random();
`ifdef DECODE_PERF_CNT_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
